image_point_stream: RTL and testbench
=====================================

Name: image_point_stream

Overview:
- Streaming RGB point-processing engine with frame-timing generation.
- Parametrised in pixels-per-clock, channel width and frame size.
- Operation mode, brightness and threshold are selectable at runtime and latched per frame.
- Pixels arrive on a valid/ready input instead of from a preloaded memory. The block sits between the pixel source (file reader or DMA) and the image writer/display sink.

Parameters:
- WIDTH, 768, pixels per line; must be a multiple of PPC.
- HEIGHT, 512, lines per frame.
- PPC, 2, pixels processed per clock beat (1, 2 or 4).
- DATA_W, 8, bits per colour channel; MAXV = 2^DATA_W-1.
- STARTUP_DELAY, 100, cycles spent in the VSYNC state per frame (≥1).
- HSYNC_DELAY, 160, cycles spent in the HSYNC state before each line (≥1).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- mode  in  2  0 bypass, 1 brightness, 2 invert-gray, 3 threshold; latched on accepted start.
- bri_value  in  DATA_W  brightness offset; latched on accepted start.
- bri_sign  in  1  1 add, 0 subtract; latched on accepted start.
- threshold  in  DATA_W  threshold level; latched on accepted start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high exactly while the FSM is in DATA.
- in_data  in  3*DATA_W*PPC  pixel k at bits [3*DATA_W*(k+1)-1 : 3*DATA_W*k], ordered {R,G,B} with R in the MSBs; pixel 0 is the leftmost.
- VSYNC  out  1  high while in VSYNC.
- HSYNC  out  1  registered; high together with out_valid.
- out_valid  out  1  registered output beat valid.
- out_data  out  3*DATA_W*PPC  processed pixels, same packing as in_data.
- ctrl_done  out  1  one-cycle end-of-frame pulse.
- underflow  out  1  sticky: in_valid was low while in DATA; cleared on accepted start.

Behaviour:
- Reset: state IDLE; all counters 0; latched config 0. Outputs in_ready, VSYNC, HSYNC, out_valid, ctrl_done and underflow are 0; out_data is 0.
- FSM states: IDLE, VSYNC, HSYNC, DATA, DONE.
  - IDLE→VSYNC when start=1; the config inputs are latched in that same cycle.
  - VSYNC lasts exactly STARTUP_DELAY cycles, then →HSYNC.
  - HSYNC lasts exactly HSYNC_DELAY cycles, then →DATA.
  - DATA: a beat is accepted when in_valid && in_ready; col advances by PPC per accepted beat.
  - On an accepted beat with col==WIDTH-PPC: col←0 and row←row+1. Go →HSYNC if row<HEIGHT-1, else →DONE.
  - DONE lasts 1 cycle, then →IDLE.
- start outside IDLE is ignored. The new frame's config never affects a frame in flight.
- Stall: in DATA with in_valid=0, the FSM holds and counters hold. underflow←1 and out_valid=0 on the next cycle.
- Latency: out_valid/HSYNC/out_data are registered 1 cycle after an accepted beat. With no accepted beat the next cycle has out_valid=0, HSYNC=0 and out_data holds its last value.
- ctrl_done = (state==DONE). It coincides with the out_valid of the frame's last beat.
- Per-pixel arithmetic. All intermediates are unsigned, DATA_W+2 bits. gray = floor((R+G+B)/3).
  - bypass: output = input.
  - brightness add: each channel min(c+bri_value, MAXV).
  - brightness subtract: each channel max(c−bri_value, 0); saturation is computed without wrap.
  - invert: R=G=B=MAXV−gray.
  - threshold: R=G=B = (gray>threshold) ? MAXV : 0. Strictly greater.
- Row order: input rows are delivered in display order. No vertical flip is performed inside the block.
- Total accepted beats per frame: WIDTH*HEIGHT/PPC.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and no ctrl_done is issued.

Test Plan:
- Common bench parameters: WIDTH=8, HEIGHT=2, PPC=2, DATA_W=8, STARTUP_DELAY=4, HSYNC_DELAY=3. "start cycle 0" means start is high for one cycle at cycle 0, with the FSM in IDLE.
- Frame timing, bypass, in_valid held 1, start cycle 0:
  - VSYNC high cycles 1–4; HSYNC-state cycles 5–7; in_ready cycles 8–11.
  - Second HSYNC-state cycles 12–14; in_ready cycles 15–18.
  - out_valid cycles 9–12 and 16–19; ctrl_done only at cycle 19; 8 beats out equal 8 beats in.
- Brightness add, bri_value=100, pixel (200,10,155) → (255,110,255). Subtract, bri_value=100, pixel (50,150,100) → (0,50,0).
- Invert and threshold, pixel (90,91,92), gray=91:
  - invert → (164,164,164).
  - threshold=91 → (0,0,0); threshold=90 → (255,255,255).
- Stall: drop in_valid for 3 cycles mid-line 0.
  - FSM holds in DATA; out_valid has a 3-cycle gap; underflow=1 and stays 1.
  - Frame still ends after exactly 8 accepted beats. Next accepted start clears underflow.
- Config latching: change mode 1→3 during line 1 → all frame outputs still use brightness. start pulses during DATA are ignored (no restart, frame completes normally).
- Reset mid-frame: assert HRESET during line 1 DATA.
  - All outputs 0 immediately, no ctrl_done.
  - After release, start produces a full correct frame (repeat the first scenario's checks).

Source files
------------

// File: rtl/image_point_stream.sv
// Streaming RGB point-processing engine with VSYNC/HSYNC frame timing.
// Pixels arrive on a valid/ready stream; processing config is latched per frame.
module image_point_stream #(
    parameter int WIDTH         = 768,
    parameter int HEIGHT        = 512,
    parameter int PPC           = 2,
    parameter int DATA_W        = 8,
    parameter int STARTUP_DELAY = 100,
    parameter int HSYNC_DELAY   = 160
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [DATA_W-1:0]        bri_value,
    input  logic                     bri_sign,
    input  logic [DATA_W-1:0]        threshold,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3*DATA_W*PPC-1:0]  in_data,
    output logic                     VSYNC,
    output logic                     HSYNC,
    output logic                     out_valid,
    output logic [3*DATA_W*PPC-1:0]  out_data,
    output logic                     ctrl_done,
    output logic                     underflow
);

    localparam int PIX_W   = 3 * DATA_W;
    localparam int BUS_W   = PIX_W * PPC;
    localparam int EXT_W   = DATA_W + 2;
    localparam int DLY_MAX = (STARTUP_DELAY > HSYNC_DELAY) ? STARTUP_DELAY : HSYNC_DELAY;
    localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W   = $clog2(HEIGHT + 1);

    localparam logic [DLY_W-1:0] VS_LAST  = DLY_W'(STARTUP_DELAY - 1);
    localparam logic [DLY_W-1:0] HS_LAST  = DLY_W'(HSYNC_DELAY - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - PPC);
    localparam logic [COL_W-1:0] COL_STEP = COL_W'(PPC);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [EXT_W-1:0] MAXV     = EXT_W'((1 << DATA_W) - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_VSYNC = 3'd1;
    localparam logic [2:0] S_HSYNC = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_BYPASS = 2'd0;
    localparam logic [1:0] OP_BRIGHT = 2'd1;
    localparam logic [1:0] OP_INVERT = 2'd2;
    localparam logic [1:0] OP_THRESH = 2'd3;

    logic [2:0]        state, state_nxt;
    logic [DLY_W-1:0]  dly_cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_bri;
    logic              cfg_sign;
    logic [DATA_W-1:0] cfg_thr;

    logic              start_acc;
    logic              beat;
    logic              line_end;
    logic              last_row;
    logic              dly_last;
    logic [BUS_W-1:0]  proc_data;

    // One pixel through the selected point operation; all intermediates
    // are DATA_W+2 bits wide so saturation never sees a wrapped value.
    function automatic logic [PIX_W-1:0] process_pixel(
        input logic [PIX_W-1:0]  px,
        input logic [1:0]        op,
        input logic [DATA_W-1:0] bri,
        input logic              add,
        input logic [DATA_W-1:0] thr
    );
        logic [EXT_W-1:0] ch [3];
        logic [EXT_W-1:0] bri_x;
        logic [EXT_W-1:0] thr_x;
        logic [EXT_W-1:0] sum;
        logic [EXT_W-1:0] gray;
        logic [EXT_W-1:0] tmp;
        logic [PIX_W-1:0] res;

        bri_x = EXT_W'(bri);
        thr_x = EXT_W'(thr);
        for (int i = 0; i < 3; i++) begin
            ch[i] = EXT_W'(px[PIX_W-1-i*DATA_W -: DATA_W]);
        end
        sum  = ch[0] + ch[1] + ch[2];
        gray = sum / EXT_W'(3);
        res  = px;

        case (op)
            OP_BYPASS: res = px;
            OP_BRIGHT: begin
                for (int i = 0; i < 3; i++) begin
                    if (add) begin
                        tmp = ch[i] + bri_x;
                        if (tmp > MAXV) begin
                            tmp = MAXV;
                        end
                    end else begin
                        tmp = (ch[i] >= bri_x) ? (ch[i] - bri_x) : '0;
                    end
                    res[PIX_W-1-i*DATA_W -: DATA_W] = DATA_W'(tmp);
                end
            end
            OP_INVERT: begin
                tmp = MAXV - gray;
                res = {3{DATA_W'(tmp)}};
            end
            OP_THRESH: begin
                tmp = (gray > thr_x) ? MAXV : '0;
                res = {3{DATA_W'(tmp)}};
            end
            default: res = px;
        endcase
        return res;
    endfunction

    assign start_acc = (state == S_IDLE) && start;
    assign in_ready  = (state == S_DATA);
    assign beat      = in_valid && in_ready;
    assign line_end  = (col == COL_LAST);
    assign last_row  = (row == ROW_LAST);
    assign dly_last  = (state == S_VSYNC) ? (dly_cnt == VS_LAST) : (dly_cnt == HS_LAST);
    assign VSYNC     = (state == S_VSYNC);
    assign ctrl_done = (state == S_DONE);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_VSYNC;
            S_VSYNC: if (dly_last) state_nxt = S_HSYNC;
            S_HSYNC: if (dly_last) state_nxt = S_DATA;
            S_DATA: begin
                if (beat && line_end) begin
                    state_nxt = last_row ? S_DONE : S_HSYNC;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        proc_data = '0;
        for (int k = 0; k < PPC; k++) begin
            proc_data[k*PIX_W +: PIX_W] = process_pixel(in_data[k*PIX_W +: PIX_W],
                                                        cfg_mode, cfg_bri, cfg_sign, cfg_thr);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The delay counter restarts on every state change and only runs in the sync states.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            dly_cnt <= '0;
        end else if (state_nxt != state) begin
            dly_cnt <= '0;
        end else if (state == S_VSYNC || state == S_HSYNC) begin
            dly_cnt <= dly_cnt + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
        end else if (beat) begin
            if (line_end) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + COL_STEP;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            cfg_mode <= '0;
            cfg_bri  <= '0;
            cfg_sign <= 1'b0;
            cfg_thr  <= '0;
        end else if (start_acc) begin
            cfg_mode <= mode;
            cfg_bri  <= bri_value;
            cfg_sign <= bri_sign;
            cfg_thr  <= threshold;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            underflow <= 1'b0;
        end else if (start_acc) begin
            underflow <= 1'b0;
        end else if (in_ready && !in_valid) begin
            underflow <= 1'b1;
        end
    end

    // out_data keeps its last value across idle cycles; only the valid/sync flags drop.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            out_valid <= 1'b0;
            HSYNC     <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= beat;
            HSYNC     <= beat;
            if (beat) begin
                out_data <= proc_data;
            end
        end
    end

endmodule

// File: tb/tb_image_point_stream.sv
// Self-checking bench for image_point_stream: timing table, spec vectors,
// and randomized frames checked against a per-pixel reference model.
module tb_image_point_stream;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int P     = 2;
    localparam int DW    = 8;
    localparam int SD    = 4;
    localparam int HD    = 3;
    localparam int BPL   = W / P;
    localparam int TOTAL = W * H / P;
    localparam int BUS_W = 3 * DW * P;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             start;
    logic [1:0]       mode;
    logic [DW-1:0]    bri_value;
    logic             bri_sign;
    logic [DW-1:0]    threshold;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic             VSYNC;
    logic             HSYNC;
    logic             out_valid;
    logic [BUS_W-1:0] out_data;
    logic             ctrl_done;
    logic             underflow;

    image_point_stream #(
        .WIDTH(W), .HEIGHT(H), .PPC(P), .DATA_W(DW),
        .STARTUP_DELAY(SD), .HSYNC_DELAY(HD)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode),
        .bri_value(bri_value), .bri_sign(bri_sign), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .VSYNC(VSYNC), .HSYNC(HSYNC), .out_valid(out_valid), .out_data(out_data),
        .ctrl_done(ctrl_done), .underflow(underflow)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  bri;
        logic        sgn;
        logic [7:0]  thr;
        bit          force_first;
        logic [23:0] first_px;
        int          stall_at;
        int          stall_len;
        bit          rand_stall;
        bit          mode_flip;
        bit          start_spam;
        int          abort_at;
        bit          trace;
    } frame_cfg_t;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [7:0]  bri;
        logic        sgn;
        logic [7:0]  thr;
        logic [23:0] px;
        logic [23:0] expv;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cyc;
    logic [23:0] first_out;
    bit          tr_vs [64];
    bit          tr_rdy[64];
    bit          tr_ov [64];
    bit          tr_done[64];
    vec_t        vecs[5];
    frame_cfg_t  cfg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic frame_cfg_t default_cfg();
        frame_cfg_t c;
        c.mode = 2'd0; c.bri = 8'd0; c.sgn = 1'b0; c.thr = 8'd0;
        c.force_first = 1'b0; c.first_px = 24'd0;
        c.stall_at = -1; c.stall_len = 0; c.rand_stall = 1'b0;
        c.mode_flip = 1'b0; c.start_spam = 1'b0; c.abort_at = -1; c.trace = 1'b0;
        return c;
    endfunction

    function automatic vec_t make_vec(input string n, input logic [1:0] m, input int b,
                                      input logic s, input int t, input int r, input int g,
                                      input int bl, input int er, input int eg, input int eb);
        vec_t v;
        v.name = n; v.mode = m; v.bri = b[7:0]; v.sgn = s; v.thr = t[7:0];
        v.px   = {r[7:0], g[7:0], bl[7:0]};
        v.expv = {er[7:0], eg[7:0], eb[7:0]};
        return v;
    endfunction

    // Reference: plain integer arithmetic on each pixel of a beat.
    function automatic logic [BUS_W-1:0] ref_beat(input logic [BUS_W-1:0] b, input frame_cfg_t c);
        logic [BUS_W-1:0] o;
        logic [23:0]      px;
        int               ch[3];
        int               gray, v, bri_i, thr_i;
        o     = b;
        bri_i = int'(c.bri);
        thr_i = int'(c.thr);
        for (int k = 0; k < P; k++) begin
            px    = b[k*24 +: 24];
            ch[0] = int'(px[23:16]);
            ch[1] = int'(px[15:8]);
            ch[2] = int'(px[7:0]);
            gray  = (ch[0] + ch[1] + ch[2]) / 3;
            for (int j = 0; j < 3; j++) begin
                case (c.mode)
                    2'd0: v = ch[j];
                    2'd1: v = c.sgn ? ch[j] + bri_i : ch[j] - bri_i;
                    2'd2: v = 255 - gray;
                    default: v = (gray > thr_i) ? 255 : 0;
                endcase
                if (v > 255) v = 255;
                if (v < 0) v = 0;
                o[k*24 + (2-j)*8 +: 8] = v[7:0];
            end
        end
        return o;
    endfunction

    task automatic clear_trace();
        for (int i = 0; i < 64; i++) begin
            tr_vs[i] = 0; tr_rdy[i] = 0; tr_ov[i] = 0; tr_done[i] = 0;
        end
    endtask

    task automatic check_timing();
        bit evs, erdy, eov, edone;
        int s;
        for (int c = 0; c <= 1 + SD + H*(HD+BPL); c++) begin
            evs  = (c >= 1 && c <= SD);
            erdy = 0;
            eov  = 0;
            for (int l = 0; l < H; l++) begin
                s = 1 + SD + (l+1)*HD + l*BPL;
                if (c >= s && c < s + BPL) erdy = 1;
                if (c >= s + 1 && c < s + 1 + BPL) eov = 1;
            end
            edone = (c == 1 + SD + H*(HD+BPL));
            check($sformatf("vsync@%0d", c), 64'(tr_vs[c]), 64'(evs));
            check($sformatf("in_ready@%0d", c), 64'(tr_rdy[c]), 64'(erdy));
            check($sformatf("out_valid@%0d", c), 64'(tr_ov[c]), 64'(eov));
            check($sformatf("ctrl_done@%0d", c), 64'(tr_done[c]), 64'(edone));
        end
    endtask

    task automatic run_frame(input frame_cfg_t c);
        logic [BUS_W-1:0] exp_q[$];
        logic [BUS_W-1:0] beat, last_exp;
        int acc, cyc, stalls, n_out;
        bit prev_acc, have_last, uf_model, done_seen, stall;
        acc = 0; cyc = 0; stalls = 0; n_out = 0;
        prev_acc = 0; have_last = 0; uf_model = 0; done_seen = 0;
        done_cyc = -1;
        last_exp = '0;
        mode = c.mode; bri_value = c.bri; bri_sign = c.sgn; threshold = c.thr;
        while (!done_seen && cyc < 400) begin
            if (cyc > 0) begin
                check("out_valid", 64'(out_valid), 64'(prev_acc));
                check("hsync", 64'(HSYNC), 64'(prev_acc));
                if (prev_acc && exp_q.size() > 0) begin
                    last_exp  = exp_q.pop_front();
                    have_last = 1;
                    check("out_data", 64'(out_data), 64'(last_exp));
                    if (n_out == 0) first_out = out_data[23:0];
                    n_out++;
                end else if (have_last) begin
                    check("out_data_hold", 64'(out_data), 64'(last_exp));
                end
            end
            if (c.trace && cyc < 64) begin
                tr_vs[cyc] = VSYNC; tr_rdy[cyc] = in_ready;
                tr_ov[cyc] = out_valid; tr_done[cyc] = ctrl_done;
            end
            if (cyc == 1) check("underflow_clear", 64'(underflow), 64'd0);
            if (ctrl_done) begin
                done_seen = 1;
                done_cyc  = cyc;
                check("done_beats", 64'(acc), 64'(TOTAL));
                check("done_with_last", 64'(out_valid), 64'd1);
                check("underflow", 64'(underflow), 64'(uf_model));
                break;
            end
            if (c.abort_at >= 0 && acc == c.abort_at && in_ready) begin
                HRESET = 1'b0;
                #1;
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_vsync", 64'(VSYNC), 64'd0);
                check("rst_hsync", 64'(HSYNC), 64'd0);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_ctrl_done", 64'(ctrl_done), 64'd0);
                check("rst_underflow", 64'(underflow), 64'd0);
                check("rst_out_data", 64'(out_data), 64'd0);
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (3) begin
                    tick();
                    check("rst_no_done", 64'(ctrl_done), 64'd0);
                end
                HRESET = 1'b1;
                tick();
                return;
            end
            start = (cyc == 0) || (c.start_spam && in_ready);
            if (c.mode_flip && acc >= 4) begin
                mode = 2'd3; bri_value = ~c.bri; bri_sign = ~c.sgn; threshold = ~c.thr;
            end
            beat = BUS_W'({$urandom(), $urandom()});
            if (c.force_first && acc == 0) beat[23:0] = c.first_px;
            in_data = beat;
            if (in_ready) begin
                stall = (acc == c.stall_at && stalls < c.stall_len) ||
                        (c.rand_stall && $urandom_range(3) == 0);
                in_valid = !stall;
                if (stall) begin
                    stalls++;
                    uf_model = 1;
                    prev_acc = 0;
                end else begin
                    exp_q.push_back(ref_beat(beat, c));
                    acc++;
                    prev_acc = 1;
                end
            end else begin
                in_valid = c.rand_stall ? 1'($urandom_range(1)) : 1'b1;
                prev_acc = 0;
            end
            tick();
            cyc++;
        end
        if (!done_seen) check("frame_timeout", 64'd0, 64'd1);
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_vsync", 64'(VSYNC), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_ctrl_done", 64'(ctrl_done), 64'd0);
        check("underflow_sticky", 64'(underflow), 64'(uf_model));
    endtask

    initial begin
        HRESET = 1'b0; start = 1'b0; mode = 2'd0; bri_value = '0; bri_sign = 1'b0;
        threshold = '0; in_valid = 1'b0; in_data = '0;
        vecs[0] = make_vec("bri_add", 2'd1, 100, 1'b1, 0, 200, 10, 155, 255, 110, 255);
        vecs[1] = make_vec("bri_sub", 2'd1, 100, 1'b0, 0, 50, 150, 100, 0, 50, 0);
        vecs[2] = make_vec("invert", 2'd2, 0, 1'b0, 0, 90, 91, 92, 164, 164, 164);
        vecs[3] = make_vec("thr_eq", 2'd3, 0, 1'b0, 91, 90, 91, 92, 0, 0, 0);
        vecs[4] = make_vec("thr_below", 2'd3, 0, 1'b0, 90, 90, 91, 92, 255, 255, 255);

        #12;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_vsync", 64'(VSYNC), 64'd0);
        check("reset_hsync", 64'(HSYNC), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ctrl_done", 64'(ctrl_done), 64'd0);
        check("reset_underflow", 64'(underflow), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        HRESET = 1'b1;
        tick();

        // Bypass frame with continuous input: exact frame timing.
        cfg = default_cfg();
        cfg.trace = 1;
        clear_trace();
        run_frame(cfg);
        check("bypass_done_cycle", 64'(done_cyc), 64'd19);
        check_timing();

        for (int i = 0; i < 5; i++) begin
            cfg = default_cfg();
            cfg.mode = vecs[i].mode; cfg.bri = vecs[i].bri; cfg.sgn = vecs[i].sgn;
            cfg.thr = vecs[i].thr; cfg.force_first = 1; cfg.first_px = vecs[i].px;
            run_frame(cfg);
            check({"vec_", vecs[i].name}, 64'(first_out), 64'(vecs[i].expv));
        end

        // Three-cycle stall in line 0 pushes the end of frame out by three cycles.
        cfg = default_cfg();
        cfg.stall_at = 2; cfg.stall_len = 3;
        run_frame(cfg);
        check("stall_done_cycle", 64'(done_cyc), 64'd22);

        // Config changes and start pulses mid-frame must not disturb the frame.
        cfg = default_cfg();
        cfg.mode = 2'd1; cfg.bri = 8'd60; cfg.sgn = 1'b1;
        cfg.mode_flip = 1; cfg.start_spam = 1;
        run_frame(cfg);
        check("latch_done_cycle", 64'(done_cyc), 64'd19);

        for (int i = 0; i < 6; i++) begin
            cfg = default_cfg();
            cfg.mode = 2'($urandom_range(3)); cfg.bri = 8'($urandom_range(255));
            cfg.sgn = 1'($urandom_range(1)); cfg.thr = 8'($urandom_range(255));
            cfg.rand_stall = 1;
            run_frame(cfg);
        end

        // Reset during line 1, then a clean frame must follow.
        cfg = default_cfg();
        cfg.stall_at = 1; cfg.stall_len = 1; cfg.abort_at = 5;
        run_frame(cfg);
        cfg = default_cfg();
        cfg.trace = 1;
        clear_trace();
        run_frame(cfg);
        check("post_reset_done_cycle", 64'(done_cyc), 64'd19);
        check_timing();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
